ft_wr_arbiter: RTL and testbench
================================

Name: ft_wr_arbiter

Overview:
- Packet scheduler for the FT600 write (FPGA-to-host) path.
- Shares the single FT write stream between two sources: the IQ sample FIFO (AFE RX, 24-bit pairs) and the CPU response FIFO (32-bit words from the Wishbone bridge).
- Grants whole packets, packs IQ pairs into 32-bit words, tracks per-packet word counts and flags protocol errors.
- Sits between the two source FIFOs and the FT600 FSM (drives its wdata/wr_available; consumes wr_req).

Parameters:
FT_DATA_WIDTH, 32, FT bus width
IQ_PAIR_WIDTH, 24, IQ FIFO word width (I in [11:0], Q in [23:12])
QSTART_BIT_INDEX, 16, bit position of Q inside a packed FT word
PKT_WORDS, 32, payload words per packet (power of two, 4..256)
BLKCNT_WIDTH, 4, width of CPU pending-block count
MAX_CPU_RUN, 4, consecutive CPU packets allowed while IQ waits

Ports:
clk  in  1  system clock (FT clock domain)
reset  in  1  asynchronous, active-high reset
iq_data_i  in  IQ_PAIR_WIDTH  IQ FIFO Q (valid 1 cycle after iq_re_o)
iq_enough_i  in  1  IQ FIFO holds >= PKT_WORDS entries
iq_empty_i  in  1  IQ FIFO empty
iq_re_o  out  1  IQ FIFO read enable
cpu_data_i  in  FT_DATA_WIDTH  CPU FIFO Q (valid 1 cycle after cpu_re_o)
cpu_blkcnt_i  in  BLKCNT_WIDTH  complete CPU blocks (PKT_WORDS each) pending
cpu_re_o  out  1  CPU FIFO read enable
cpu_blk_done_o  out  1  one-cycle pulse: a CPU block fully consumed
re_i  in  1  word read request from FT FSM
data_o  out  FT_DATA_WIDTH  word to FT FSM, valid the cycle after re_i
available_o  out  1  a granted packet is open for reading
src_o  out  2  current grant: 00 none, 01 IQ, 10 CPU
error_o  out  1  sticky protocol error

Behaviour:
- Reset (async, active-high): state IDLE; word count 0; CPU-run count 0; every output 0 (data_o = 0, src_o = 00).
- States: IDLE, IQ_PKT, CPU_PKT (plus HDR when the optional feature is compiled in).
- Eligibility:
  - IQ is eligible when iq_enough_i = 1.
  - CPU is eligible when cpu_blkcnt_i != 0.
- IDLE, decision registered (one cycle):
  - Both eligible: CPU wins unless run count = MAX_CPU_RUN, in which case IQ wins.
  - Only one eligible: that source wins.
  - Neither eligible: stay in IDLE.
- Run counter:
  - +1 on each CPU grant while IQ is eligible.
  - Cleared on any IQ grant, or on a CPU grant while IQ is not eligible.
  - Saturates at MAX_CPU_RUN.
- In IQ_PKT / CPU_PKT:
  - available_o = 1 and src_o = tag.
  - iq_re_o / cpu_re_o = re_i gated by grant (combinational).
  - Word count increments on each re_i.
- On the re_i that reads word PKT_WORDS-1:
  - Next state is IDLE; available_o drops the following cycle.
  - In CPU_PKT, cpu_blk_done_o pulses in that same cycle.
  - Minimum one idle cycle between packets; no back-to-back grant in the same cycle.
- data_o: combinational mux on a one-cycle-delayed source tag.
  - IQ: zero-extended, with I in [11:0] and Q in [QSTART_BIT_INDEX+11:QSTART_BIT_INDEX]; all other bits 0.
  - CPU: passthrough.
  - Otherwise: 0.
- The FT FSM must not assert re_i more than PKT_WORDS times per grant. Any extra re_i is ignored (no FIFO pop).
- Errors (error_o set, held until reset):
  - re_i while in IDLE.
  - re_i in IQ_PKT while iq_empty_i = 1 (FIFO not popped).
- Eligibility inputs that change mid-packet do not affect the open packet.
- Reset mid-packet: immediate return to IDLE; the partial packet is abandoned, and the CPU block is not reported done.

Optional Feature:
- Macro: FT_PKT_HDR_EN.
- When defined, each grant first enters HDR, emitting one header word before the payload:
  - [31:28] = 4'hA
  - [27:24] = 0001 IQ / 0010 CPU
  - [23:16] = 8-bit packet sequence number (wraps 255 -> 0, reset 0)
  - [15:0] = PKT_WORDS
- Reading the header consumes one re_i, pops no FIFO, and delivers data_o the next cycle.
- The packet is then PKT_WORDS+1 words.
- When undefined, there is no HDR state and packets carry payload only.

Test Plan:
- Reset then idle inputs -> all outputs 0, available_o stays 0 for 100 cycles.
- iq_enough_i=1, iq_data_i = 24'hABC123, 32 re_i pulses:
  - expected: 32 iq_re_o pulses, data_o = 32'h0ABC_0123, src_o = 01, then IDLE.
- cpu_blkcnt_i=2 with iq_enough_i=1 held (MAX_CPU_RUN=4, cpu_blkcnt_i kept nonzero):
  - expected grant order: CPU, CPU, CPU, CPU, IQ, CPU.
  - cpu_blk_done_o pulses once per CPU packet.
- re_i asserted in IDLE -> error_o=1 and stays 1; no FIFO read.
- Reset asserted at word 10 of a CPU packet -> outputs 0 within the same cycle, no cpu_blk_done_o, clean grant after release.
- FT_PKT_HDR_EN, three IQ packets -> headers 32'hA100_0020, 32'hA101_0020, 32'hA102_0020, each followed by 32 payload words.

Source files
------------

// File: rtl/ft_wr_arbiter.sv
// FT600 write-path packet scheduler: grants whole packets to the IQ or CPU FIFO and packs IQ pairs.
// Optional per-packet header word when FT_PKT_HDR_EN is defined.
module ft_wr_arbiter #(
   parameter int FT_DATA_WIDTH    = 32,
   parameter int IQ_PAIR_WIDTH    = 24,
   parameter int QSTART_BIT_INDEX = 16,
   parameter int PKT_WORDS        = 32,
   parameter int BLKCNT_WIDTH     = 4,
   parameter int MAX_CPU_RUN      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [IQ_PAIR_WIDTH-1:0] iq_data_i,
   input  logic                     iq_enough_i,
   input  logic                     iq_empty_i,
   output logic                     iq_re_o,
   input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
   input  logic [BLKCNT_WIDTH-1:0]  cpu_blkcnt_i,
   output logic                     cpu_re_o,
   output logic                     cpu_blk_done_o,
   input  logic                     re_i,
   output logic [FT_DATA_WIDTH-1:0] data_o,
   output logic                     available_o,
   output logic [1:0]               src_o,
   output logic                     error_o
);

   localparam int CW = $clog2(PKT_WORDS);
   localparam int RW = $clog2(MAX_CPU_RUN + 1);
   localparam int HW = IQ_PAIR_WIDTH / 2;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_IQ   = 2'b01;
   localparam logic [1:0] SRC_CPU  = 2'b10;
   localparam logic [1:0] SEL_HDR  = 2'b11;

`ifdef FT_PKT_HDR_EN
   typedef enum logic [1:0] {IDLE, IQ_PKT, CPU_PKT, HDR} state_t;
`else
   typedef enum logic [1:0] {IDLE, IQ_PKT, CPU_PKT} state_t;
`endif

   state_t          state, state_n;
   logic [CW-1:0]   wcnt, wcnt_n;
   logic [RW-1:0]   run, run_n;
   logic [1:0]      gnt, gnt_n;
   logic [1:0]      sel_d, sel_n;
   logic            err_n;
   logic            iq_ok, cpu_ok, last;
   state_t          iq_first, cpu_first;

`ifdef FT_PKT_HDR_EN
   logic [7:0]               seq, seq_n;
   logic [FT_DATA_WIDTH-1:0] hdr_q, hdr_n;
`endif

   assign iq_ok  = iq_enough_i;
   assign cpu_ok = (cpu_blkcnt_i != '0);
   assign last   = (wcnt == CW'(PKT_WORDS - 1));

`ifdef FT_PKT_HDR_EN
   assign iq_first  = HDR;
   assign cpu_first = HDR;
`else
   assign iq_first  = IQ_PKT;
   assign cpu_first = CPU_PKT;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         wcnt    <= '0;
         run     <= '0;
         gnt     <= SRC_NONE;
         sel_d   <= SRC_NONE;
         error_o <= 1'b0;
`ifdef FT_PKT_HDR_EN
         seq     <= '0;
         hdr_q   <= '0;
`endif
      end else begin
         state   <= state_n;
         wcnt    <= wcnt_n;
         run     <= run_n;
         gnt     <= gnt_n;
         sel_d   <= sel_n;
         error_o <= err_n;
`ifdef FT_PKT_HDR_EN
         seq     <= seq_n;
         hdr_q   <= hdr_n;
`endif
      end
   end

   always_comb begin
      state_n        = state;
      wcnt_n         = wcnt;
      run_n          = run;
      gnt_n          = gnt;
      sel_n          = SRC_NONE;
      err_n          = error_o;
      iq_re_o        = 1'b0;
      cpu_re_o       = 1'b0;
      cpu_blk_done_o = 1'b0;
      available_o    = 1'b0;
      src_o          = SRC_NONE;
`ifdef FT_PKT_HDR_EN
      seq_n          = seq;
      hdr_n          = hdr_q;
`endif
      case (state)
         IDLE: begin
            wcnt_n = '0;
            if (re_i) err_n = 1'b1;
            // CPU yields to a waiting IQ source only after MAX_CPU_RUN consecutive grants
            if (cpu_ok && (!iq_ok || run != RW'(MAX_CPU_RUN))) begin
               gnt_n   = SRC_CPU;
               run_n   = iq_ok ? run + RW'(1) : '0;
               state_n = cpu_first;
            end else if (iq_ok) begin
               gnt_n   = SRC_IQ;
               run_n   = '0;
               state_n = iq_first;
            end
         end
`ifdef FT_PKT_HDR_EN
         HDR: begin
            available_o = 1'b1;
            src_o       = gnt;
            if (re_i) begin
               sel_n   = SEL_HDR;
               hdr_n   = FT_DATA_WIDTH'({4'hA, (gnt == SRC_CPU) ? 4'b0010 : 4'b0001,
                                         seq, 16'(PKT_WORDS)});
               seq_n   = seq + 8'd1;
               state_n = (gnt == SRC_CPU) ? CPU_PKT : IQ_PKT;
            end
         end
`endif
         IQ_PKT: begin
            available_o = 1'b1;
            src_o       = gnt;
            if (re_i) begin
               sel_n   = SRC_IQ;
               iq_re_o = !iq_empty_i;
               if (iq_empty_i) err_n = 1'b1;
               wcnt_n  = wcnt + CW'(1);
               if (last) state_n = IDLE;
            end
         end
         CPU_PKT: begin
            available_o = 1'b1;
            src_o       = gnt;
            if (re_i) begin
               sel_n          = SRC_CPU;
               cpu_re_o       = 1'b1;
               cpu_blk_done_o = last;
               wcnt_n         = wcnt + CW'(1);
               if (last) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // FIFO Q is valid the cycle after the pop, so the mux follows the delayed select
   always_comb begin
      data_o = '0;
      case (sel_d)
         SRC_IQ: begin
            data_o[HW-1:0]                 = iq_data_i[HW-1:0];
            data_o[QSTART_BIT_INDEX +: HW] = iq_data_i[IQ_PAIR_WIDTH-1:HW];
         end
         SRC_CPU: data_o = cpu_data_i;
`ifdef FT_PKT_HDR_EN
         SEL_HDR: data_o = hdr_q;
`endif
         default: data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_ft_wr_arbiter.sv
// Scoreboard bench for ft_wr_arbiter: expected words queued on each read, compared when data_o is due.
module tb_ft_wr_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] iq_data_i = 24'h0;
   logic        iq_enough_i = 1'b0;
   logic        iq_empty_i = 1'b0;
   logic        iq_re_o;
   logic [31:0] cpu_data_i = 32'h0;
   logic [3:0]  cpu_blkcnt_i = 4'd0;
   logic        cpu_re_o;
   logic        cpu_blk_done_o;
   logic        re_i = 1'b0;
   logic [31:0] data_o;
   logic        available_o;
   logic [1:0]  src_o;
   logic        error_o;

   int total = 0;
   int bad = 0;
   int cpu_pops = 0;
   int iq_pops = 0;
   int done_cnt = 0;
   int exp_cpu = 0;
   int hdr_seq = 0;
   logic [31:0] sb[$];

   ft_wr_arbiter dut (
      .clk(clk), .reset(reset),
      .iq_data_i(iq_data_i), .iq_enough_i(iq_enough_i), .iq_empty_i(iq_empty_i), .iq_re_o(iq_re_o),
      .cpu_data_i(cpu_data_i), .cpu_blkcnt_i(cpu_blkcnt_i), .cpu_re_o(cpu_re_o),
      .cpu_blk_done_o(cpu_blk_done_o), .re_i(re_i), .data_o(data_o),
      .available_o(available_o), .src_o(src_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   // source FIFO stand-ins: CPU FIFO yields an incrementing word per pop
   always @(posedge clk) begin
      if (cpu_re_o) begin
         cpu_data_i <= 32'hC0DE_0000 + cpu_pops;
         cpu_pops   <= cpu_pops + 1;
      end
      if (iq_re_o) iq_pops <= iq_pops + 1;
      if (cpu_blk_done_o) done_cnt <= done_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] pack_iq(input logic [23:0] v);
      return {4'h0, v[23:12], 4'h0, v[11:0]};
   endfunction

   // Called at a negedge; waits for the grant, then reads nwords payload words back to back.
   task automatic read_pkt(input logic [1:0] exp_src, input int nwords);
      int w = 0;
      logic [31:0] exp, got;
      logic exp_iq, exp_cpu_re, exp_done;
      logic [7:0] s8;
      while (!available_o && w < 50) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (available_o !== 1'b1) begin
         bad++;
         $display("FAIL grant_wait: available_o=%b required 1", available_o);
         return;
      end
      total++;
      if (src_o !== exp_src) begin
         bad++;
         $display("FAIL grant_src: src_o=%b required %b", src_o, exp_src);
      end
`ifdef FT_PKT_HDR_EN
      s8  = hdr_seq[7:0];
      exp = {4'hA, (exp_src == 2'b10) ? 4'h2 : 4'h1, s8, 16'h0020};
      hdr_seq++;
      re_i = 1'b1;
      sb.push_back(exp);
      #1;
      total++;
      if (iq_re_o !== 1'b0 || cpu_re_o !== 1'b0) begin
         bad++;
         $display("FAIL hdr_nopop: iq_re=%b cpu_re=%b required 0 0", iq_re_o, cpu_re_o);
      end
      @(negedge clk);
      got = sb.pop_front();
      total++;
      if (data_o !== got) begin
         bad++;
         $display("FAIL hdr_word: data_o=%h required %h", data_o, got);
      end
`else
      s8 = 8'h0;
`endif
      for (int k = 0; k < nwords; k++) begin
         exp_iq     = (exp_src == 2'b01) && !iq_empty_i;
         exp_cpu_re = (exp_src == 2'b10);
         exp_done   = exp_cpu_re && (k == 31);
         if (exp_src == 2'b10) begin
            exp = 32'hC0DE_0000 + exp_cpu;
            exp_cpu++;
         end else exp = pack_iq(iq_data_i);
         re_i = 1'b1;
         sb.push_back(exp);
         #1;
         total++;
         if (iq_re_o !== exp_iq || cpu_re_o !== exp_cpu_re || cpu_blk_done_o !== exp_done) begin
            bad++;
            $display("FAIL strobes w%0d: iq_re=%b cpu_re=%b done=%b required %b %b %b",
                     k, iq_re_o, cpu_re_o, cpu_blk_done_o, exp_iq, exp_cpu_re, exp_done);
         end
         @(negedge clk);
         re_i = 1'b0;
         if (sb.size() > 0) begin
            got = sb.pop_front();
            total++;
            if (data_o !== got) begin
               bad++;
               $display("FAIL payload w%0d: data_o=%h required %h", k, data_o, got);
            end
         end
      end
      if (nwords == 32) begin
         total++;
         if (available_o !== 1'b0 || src_o !== 2'b00) begin
            bad++;
            $display("FAIL pkt_end: available_o=%b src_o=%b required 0 00", available_o, src_o);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #1;
      total++;
      if ({available_o, src_o, error_o, iq_re_o, cpu_re_o, cpu_blk_done_o} !== 7'b0 || data_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_outs: avail=%b src=%b err=%b data=%h required all 0",
                  available_o, src_o, error_o, data_o);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      hdr_seq = 0;
   endtask

   task automatic test_idle;
      int busy = 0;
      repeat (100) begin
         @(negedge clk);
         if (available_o || src_o != 2'b00 || iq_re_o || cpu_re_o || data_o != 32'h0) busy++;
      end
      total++;
      if (busy !== 0) begin
         bad++;
         $display("FAIL idle_quiet: active cycles=%0d required 0", busy);
      end
   endtask

   task automatic test_iq;
      int p0 = iq_pops;
      iq_data_i = 24'hABC123;
      iq_enough_i = 1'b1;
      @(negedge clk);
      iq_enough_i = 1'b0;
      read_pkt(2'b01, 32);
      total++;
      if (iq_pops - p0 !== 32) begin
         bad++;
         $display("FAIL iq_pops: got %0d required 32", iq_pops - p0);
      end
      total++;
      if (pack_iq(24'hABC123) !== 32'h0ABC_0123) begin
         bad++;
         $display("FAIL iq_pack_model: got %h required 0abc0123", pack_iq(24'hABC123));
      end
   endtask

   task automatic test_arbitration;
      logic [1:0] order[6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
      int d0 = done_cnt;
      iq_data_i = 24'h5A53C3;
      cpu_blkcnt_i = 4'd2;
      iq_enough_i = 1'b1;
      for (int i = 0; i < 6; i++) read_pkt(order[i], 32);
      cpu_blkcnt_i = 4'd0;
      iq_enough_i = 1'b0;
      @(negedge clk);
      total++;
      if (done_cnt - d0 !== 5) begin
         bad++;
         $display("FAIL blk_done_count: got %0d required 5", done_cnt - d0);
      end
   endtask

   task automatic test_error_idle;
      int pi = iq_pops;
      int pc = cpu_pops;
      re_i = 1'b1;
      #1;
      total++;
      if (iq_re_o !== 1'b0 || cpu_re_o !== 1'b0) begin
         bad++;
         $display("FAIL idle_re_pop: iq_re=%b cpu_re=%b required 0 0", iq_re_o, cpu_re_o);
      end
      @(negedge clk);
      re_i = 1'b0;
      total++;
      if (error_o !== 1'b1) begin
         bad++;
         $display("FAIL err_set: error_o=%b required 1", error_o);
      end
      repeat (5) @(negedge clk);
      total++;
      if (error_o !== 1'b1 || iq_pops != pi || cpu_pops != pc) begin
         bad++;
         $display("FAIL err_sticky: error_o=%b pops=%0d/%0d required 1 and %0d/%0d",
                  error_o, iq_pops, cpu_pops, pi, pc);
      end
   endtask

   task automatic test_reset_mid_packet;
      int d0;
      cpu_blkcnt_i = 4'd1;
      @(negedge clk);
      cpu_blkcnt_i = 4'd0;
      read_pkt(2'b10, 10);
      d0 = done_cnt;
      re_i = 1'b1;
      reset = 1'b1;
      #1;
      total++;
      if ({available_o, src_o, error_o, cpu_re_o, cpu_blk_done_o} !== 6'b0 || data_o !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset_outs: avail=%b src=%b err=%b cpu_re=%b done=%b data=%h required 0",
                  available_o, src_o, error_o, cpu_re_o, cpu_blk_done_o, data_o);
      end
      @(negedge clk);
      re_i = 1'b0;
      reset = 1'b0;
      hdr_seq = 0;
      sb.delete();
      total++;
      if (done_cnt != d0) begin
         bad++;
         $display("FAIL mid_reset_done: pulses=%0d required 0", done_cnt - d0);
      end
      cpu_blkcnt_i = 4'd1;
      @(negedge clk);
      cpu_blkcnt_i = 4'd0;
      read_pkt(2'b10, 32);
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++;
         $display("FAIL post_reset_done: pulses=%0d required 1", done_cnt - d0);
      end
   endtask

   task automatic test_iq_empty_err;
      int p0 = iq_pops;
      iq_data_i = 24'h123456;
      iq_enough_i = 1'b1;
      @(negedge clk);
      iq_enough_i = 1'b0;
      iq_empty_i = 1'b1;
      read_pkt(2'b01, 32);
      iq_empty_i = 1'b0;
      total++;
      if (error_o !== 1'b1 || iq_pops != p0) begin
         bad++;
         $display("FAIL iq_empty_err: error_o=%b pops=%0d required 1 and 0", error_o, iq_pops - p0);
      end
   endtask

`ifdef FT_PKT_HDR_EN
   task automatic test_hdr;
      test_reset();
      iq_data_i = 24'hABC123;
      for (int i = 0; i < 3; i++) begin
         iq_enough_i = 1'b1;
         @(negedge clk);
         iq_enough_i = 1'b0;
         read_pkt(2'b01, 32);
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_idle();
      test_iq();
      test_arbitration();
      test_error_idle();
      test_reset_mid_packet();
      test_iq_empty_err();
`ifdef FT_PKT_HDR_EN
      test_hdr();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
